// File: rtl/systolic_pkg.sv
// Shared defaults, FSM state type and the ReLU/saturation helper used by the
// OFM write-back path.
package systolic_pkg;

    localparam int SYSTOLIC_SIZE_DEF = 16;
    localparam int PSUM_WIDTH_DEF    = 32;
    localparam int OUT_WIDTH_DEF     = 16;
    localparam int OFM_H_DEF         = 32;
    localparam int OFM_W_DEF         = 32;
    localparam int NUM_FILTER_DEF    = 16;
    localparam int PLANE_SIZE_DEF    = OFM_H_DEF * OFM_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_e;

    // Optional ReLU, then clamp to the signed range of an out_w-bit word.
    function automatic logic signed [63:0] sat_relu(
        input logic signed [63:0] v,
        input int                 out_w,
        input bit                 relu_en
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r  = v;
        if (relu_en && (r < 64'sd0)) r = 64'sd0;
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/wb_beat_fifo.sv
// Two-entry beat buffer between the systolic array and the write-back drain.
// The caller guarantees push only when count_o < 2 and pop only when count_o > 0.
module wb_beat_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    // NOTE: storage is deliberately not reset; count_q alone says which entries hold live beats.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ofm_writeback.sv
// Buffers systolic-array result beats and serialises them, one ReLU'd and
// saturated element per cycle, into the OFM RAM write port.
module ofm_writeback
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
    parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
    parameter int OUT_WIDTH     = OUT_WIDTH_DEF,
    parameter int OFM_H         = OFM_H_DEF,
    parameter int OFM_W         = OFM_W_DEF,
    parameter int NUM_FILTER    = NUM_FILTER_DEF,
    parameter int ADDR_WIDTH    = 14,
    parameter bit RELU_EN       = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] in_data,
    input  logic [$clog2(NUM_FILTER)-1:0]       in_filter,
    input  logic [$clog2(OFM_H*OFM_W)-1:0]      in_pix,
    input  logic                                in_last,
    output logic                                ofm_we,
    output logic [ADDR_WIDTH-1:0]               ofm_addr,
    output logic [OUT_WIDTH-1:0]                ofm_din,
    output logic                                done,
    output logic                                err
);

    localparam int PLANE_SIZE = OFM_H * OFM_W;
    localparam int FILT_W     = $clog2(NUM_FILTER);
    localparam int PIX_W      = $clog2(PLANE_SIZE);
    localparam int ELEM_W     = $clog2(SYSTOLIC_SIZE);
    localparam int DATA_W     = SYSTOLIC_SIZE * PSUM_WIDTH;
    localparam int BEAT_W     = DATA_W + FILT_W + PIX_W + 1;
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(SYSTOLIC_SIZE - 1);

    logic [1:0]        fifo_count;
    logic [BEAT_W-1:0] head_beat;
    logic              push;
    logic              pop;
    logic              issue;

    logic [DATA_W-1:0] head_data;
    logic [FILT_W-1:0] head_filter;
    logic [PIX_W-1:0]  head_pix;
    logic              head_last;

    wb_state_e state_q, state_d;

    logic [ELEM_W-1:0]     elem_q, elem_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [OUT_WIDTH-1:0]  din_q, din_d;
    logic                  err_q, err_d;
    logic                  done_pend_q;
    logic                  done_q;

    logic signed [PSUM_WIDTH-1:0] elem_val;
    logic signed [63:0]           elem_sat;
    logic [31:0]                  pix_off;
    logic [31:0]                  filt_base;
    logic [31:0]                  addr_full;
    logic                         in_range;

    // No bypass: readiness depends only on the registered occupancy.
    assign in_ready = rst_n && (fifo_count < 2'd2);
    assign push     = in_valid && in_ready;

    wb_beat_fifo #(
        .WIDTH(BEAT_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .din_i  ({in_last, in_pix, in_filter, in_data}),
        .dout_o (head_beat),
        .count_o(fifo_count)
    );

    assign head_data   = head_beat[DATA_W-1:0];
    assign head_filter = head_beat[DATA_W +: FILT_W];
    assign head_pix    = head_beat[DATA_W+FILT_W +: PIX_W];
    assign head_last   = head_beat[BEAT_W-1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fifo_count != 2'd0) state_d = DRAIN;
            DRAIN:   if ((elem_q == LAST_ELEM) && (fifo_count == 2'd1) && !push) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue = (state_q == DRAIN) || (fifo_count != 2'd0);
        pop   = issue && (elem_q == LAST_ELEM);
    end

    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    always_comb begin
        elem_val  = head_data[elem_q*PSUM_WIDTH +: PSUM_WIDTH];
        elem_sat  = sat_relu(64'(elem_val), OUT_WIDTH, RELU_EN);
        pix_off   = 32'(head_pix) + 32'(elem_q);
        filt_base = 32'(head_filter) * 32'(PLANE_SIZE);
        addr_full = filt_base + pix_off;
        in_range  = (pix_off < 32'(PLANE_SIZE)) &&
                    (filt_base < 32'(NUM_FILTER * PLANE_SIZE));

        elem_d = elem_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        err_d  = err_q;
        if (issue) begin
            elem_d = (elem_q == LAST_ELEM) ? '0 : elem_q + 1'b1;
            if (in_range) begin
                we_d   = 1'b1;
                addr_d = addr_full[ADDR_WIDTH-1:0];
                din_d  = elem_sat[OUT_WIDTH-1:0];
            end else begin
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            err_q       <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            elem_q      <= elem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            err_q       <= err_d;
            done_pend_q <= pop && head_last;
            done_q      <= done_pend_q;
        end
    end

    assign ofm_we   = we_q;
    assign ofm_addr = addr_q;
    assign ofm_din  = din_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Scoreboard bench for ofm_writeback: a ReLU instance and a no-ReLU instance
// share stimulus; a negedge monitor checks every RAM write against the queues.
module tb_ofm_writeback;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] din;
    } wr_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [511:0] in_data;
    logic [3:0]   in_filter;
    logic [9:0]   in_pix;
    logic         in_last;

    logic         in_ready, ofm_we, done, err;
    logic [13:0]  ofm_addr;
    logic [15:0]  ofm_din;
    logic         in_ready_nr, ofm_we_nr, done_nr, err_nr;
    logic [13:0]  ofm_addr_nr;
    logic [15:0]  ofm_din_nr;

    wr_t q_r[$];
    wr_t q_nr[$];

    int checks    = 0;
    int failures  = 0;
    int wr_cnt    = 0;
    int burst_cnt = 0;
    int done_cnt  = 0;
    logic        prev_we   = 1'b0;
    logic [13:0] prev_addr = '0;
    logic [13:0] done_addr_exp = '0;

    ofm_writeback #(.RELU_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_filter(in_filter), .in_pix(in_pix), .in_last(in_last),
        .ofm_we(ofm_we), .ofm_addr(ofm_addr), .ofm_din(ofm_din), .done(done), .err(err)
    );

    ofm_writeback #(.RELU_EN(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nr),
        .in_data(in_data), .in_filter(in_filter), .in_pix(in_pix), .in_last(in_last),
        .ofm_we(ofm_we_nr), .ofm_addr(ofm_addr_nr), .ofm_din(ofm_din_nr), .done(done_nr),
        .err(err_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input bit relu);
        if (relu && v < 0) v = 0;
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model(input int vals[16], output int er[16], output int enr[16]);
        for (int i = 0; i < 16; i++) begin
            er[i]  = sat(vals[i], 1'b1);
            enr[i] = sat(vals[i], 1'b0);
        end
    endtask

    // Called at a negedge; leaves in_valid high and returns at the negedge after acceptance.
    task automatic send_beat(input logic [3:0] f, input logic [9:0] p, input logic last,
                             input int vals[16], input int er[16], input int enr[16],
                             input int n_exp);
        int n;
        wr_t w;
        for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = vals[i];
        in_filter = f;
        in_pix    = p;
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        for (int e = 0; e < n_exp; e++) begin
            if (int'(p) + e < 1024) begin
                w.addr = 14'(int'(f) * 1024 + int'(p) + e);
                w.din  = 16'(er[e]);
                q_r.push_back(w);
                w.din  = 16'(enr[e]);
                q_nr.push_back(w);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q_r.size() != 0 || q_nr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(q_r.size() + q_nr.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        wr_t w;
        if (ofm_we) begin
            wr_cnt++;
            if (!prev_we) burst_cnt++;
            check("write_expected", 64'(q_r.size() != 0), 64'd1);
            if (q_r.size() != 0) begin
                w = q_r.pop_front();
                check("wr_addr", 64'(ofm_addr), 64'(w.addr));
                check("wr_din", 64'(ofm_din), 64'(w.din));
            end
        end
        if (ofm_we_nr) begin
            check("write_expected_nr", 64'(q_nr.size() != 0), 64'd1);
            if (q_nr.size() != 0) begin
                w = q_nr.pop_front();
                check("wr_addr_nr", 64'(ofm_addr_nr), 64'(w.addr));
                check("wr_din_nr", 64'(ofm_din_nr), 64'(w.din));
            end
        end
        if (done) begin
            done_cnt++;
            check("done_after_final_write", {49'd0, prev_we, prev_addr}, {49'd0, 1'b1, done_addr_exp});
        end
        prev_we   = ofm_we;
        prev_addr = ofm_addr;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[16];
        int er[16];
        int enr[16];
        int base_wr, base_burst;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        in_filter = '0; in_pix = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(ofm_we), 64'd0);
        check("rst_addr", 64'(ofm_addr), 64'd0);
        check("rst_din", 64'(ofm_din), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // Single beat, filter 2, pix 64: 2112..2127, din i*100.
        for (int i = 0; i < 16; i++) vals[i] = i * 100;
        model(vals, er, enr);
        send_beat(4'd2, 10'd64, 1'b0, vals, er, enr, 16);
        in_valid = 1'b0;
        check("lat_we_accept_cycle", 64'(ofm_we), 64'd0);
        @(negedge clk);
        check("lat_we_first", 64'(ofm_we), 64'd1);
        check("lat_addr_first", 64'(ofm_addr), 64'd2112);
        wait_drain(100);
        check("single_no_done", 64'(done_cnt), 64'd0);

        // Saturation / ReLU, hand-computed for both instances.
        for (int i = 0; i < 16; i++) begin
            vals[i] = i; er[i] = i; enr[i] = i;
        end
        vals[0] = -5;     er[0] = 0;     enr[0] = -5;
        vals[1] = 40000;  er[1] = 32767; enr[1] = 32767;
        vals[2] = 32767;  er[2] = 32767; enr[2] = 32767;
        vals[3] = -70000; er[3] = 0;     enr[3] = -32768;
        send_beat(4'd0, 10'd200, 1'b0, vals, er, enr, 16);
        in_valid = 1'b0;
        wait_drain(100);

        // Back-pressure: four beats with in_valid held high.
        base_wr = wr_cnt;
        base_burst = burst_cnt;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) vals[i] = b * 1000 + i * 3 - 20;
            model(vals, er, enr);
            send_beat(4'(4 + b), 10'(b * 16), 1'b0, vals, er, enr, 16);
            if (b == 1) check("bp_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wait_drain(300);
        check("bp_write_count", 64'(wr_cnt - base_wr), 64'd64);
        check("bp_single_burst", 64'(burst_cnt - base_burst), 64'd1);

        // Last beat of the layer: final address 16383, then one done pulse.
        done_addr_exp = 14'd16383;
        for (int i = 0; i < 16; i++) vals[i] = i * 1000 - 5000;
        model(vals, er, enr);
        send_beat(4'd15, 10'd1008, 1'b1, vals, er, enr, 16);
        in_valid = 1'b0;
        wait_drain(100);
        check("done_pulse_count", 64'(done_cnt), 64'd1);
        check("err_before_oor", 64'(err), 64'd0);

        // Out-of-range: only elements 0..3 land (4092..4095).
        for (int i = 0; i < 16; i++) vals[i] = i * 10 + 1;
        model(vals, er, enr);
        send_beat(4'd3, 10'd1020, 1'b0, vals, er, enr, 16);
        in_valid = 1'b0;
        wait_drain(100);
        check("oor_err", 64'(err), 64'd1);
        check("oor_err_nr", 64'(err_nr), 64'd1);

        // err stays set through a normal beat.
        for (int i = 0; i < 16; i++) vals[i] = 7 - i;
        model(vals, er, enr);
        send_beat(4'd9, 10'd500, 1'b0, vals, er, enr, 16);
        in_valid = 1'b0;
        wait_drain(100);
        check("err_sticky", 64'(err), 64'd1);
        check("done_count_unchanged", 64'(done_cnt), 64'd1);

        // Mid-drain reset: only elements 0..6 of the first beat may be written.
        for (int i = 0; i < 16; i++) vals[i] = 300 + i;
        model(vals, er, enr);
        send_beat(4'd1, 10'd0, 1'b0, vals, er, enr, 7);
        send_beat(4'd6, 10'd32, 1'b1, vals, er, enr, 0);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_we", 64'(ofm_we), 64'd0);
        check("mid_rst_addr", 64'(ofm_addr), 64'd0);
        check("mid_rst_din", 64'(ofm_din), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_pending", 64'(q_r.size() + q_nr.size()), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready_release", 64'(in_ready), 64'd1);
        base_wr = wr_cnt;
        repeat (40) @(negedge clk);
        check("no_stale_writes", 64'(wr_cnt - base_wr), 64'd0);
        check("no_stale_done", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
